// File: rtl/key_cmd_scheduler_pkg.sv
// key_cmd_scheduler_pkg
//   Shared types and helpers for the key command scheduler.
//   - state_t    : arbiter FSM states (IDLE, OFFER)
//   - key_to_cmd : maps a key index to {sel, inc}; the key pair 2n/2n+1
//                  drives counter n, the odd key of the pair increments.
package key_cmd_scheduler_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  localparam int unsigned SEL_MAX_W = 16;

  // Result is {sel[SEL_MAX_W-1:0], inc}; callers truncate sel to their width.
  function automatic logic [SEL_MAX_W:0] key_to_cmd(input int unsigned idx);
    return {SEL_MAX_W'(idx >> 1), idx[0]};
  endfunction

endpackage

// File: rtl/key_cmd_scheduler_debounce.sv
// key_debounce
//   Per-key front end: 2-flop synchronizer, stability counter producing the
//   debounced level, and a one-cycle press event on its rising edge.
//   Optional macro KEY_CMD_SCHEDULER_AUTOREPEAT_EN adds auto-repeat events
//   (first after rpt_delay cycles, then every rpt_period cycles while held).
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   key   : raw asynchronous key level, active-high
//   press : one-cycle press (or repeat) event
module key_debounce #(
  parameter int deb_cycles = 4
`ifdef KEY_CMD_SCHEDULER_AUTOREPEAT_EN
  ,
  parameter int rpt_delay  = 20,
  parameter int rpt_period = 8
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);

  localparam int DW = (deb_cycles > 1) ? $clog2(deb_cycles) : 1;

  logic          sync_1;
  logic          sync_2;
  logic          level;
  logic [DW-1:0] cnt;
  logic          settle;
  logic          rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= key;
      sync_2 <= sync_1;
    end
  end

  // cnt only runs while the synchronized value disagrees with the accepted
  // level; a bounce back to the old level lands in the equal branch and
  // restarts the count.
  assign settle = (sync_2 != level) && (cnt == DW'(deb_cycles - 1));
  assign rise   = settle & sync_2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync_2 == level) begin
      cnt <= '0;
    end else if (settle) begin
      level <= sync_2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef KEY_CMD_SCHEDULER_AUTOREPEAT_EN
  localparam int RPT_MAX = (rpt_delay > rpt_period) ? rpt_delay : rpt_period;
  localparam int RW      = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  logic [RW-1:0] rpt_cnt;
  logic          rpt_first_done;

  // The release edge (settle with sync low) wins over a repeat that would
  // otherwise fire in the same cycle the key is accepted as released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press          <= 1'b0;
      rpt_cnt        <= '0;
      rpt_first_done <= 1'b0;
    end else begin
      press <= rise;
      if (settle || !level) begin
        rpt_cnt        <= '0;
        rpt_first_done <= 1'b0;
      end else if (!rpt_first_done && (rpt_cnt == RW'(rpt_delay - 1))) begin
        press          <= 1'b1;
        rpt_cnt        <= '0;
        rpt_first_done <= 1'b1;
      end else if (rpt_first_done && (rpt_cnt == RW'(rpt_period - 1))) begin
        press   <= 1'b1;
        rpt_cnt <= '0;
      end else begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press <= 1'b0;
    end else begin
      press <= rise;
    end
  end
`endif

endmodule

// File: rtl/key_cmd_scheduler.sv
// key_cmd_scheduler
//   Debounces w_key push buttons, queues one press per key and offers the
//   queued presses as increment/decrement commands over a valid/ready
//   handshake, arbitrated round-robin.
//   Optional macro KEY_CMD_SCHEDULER_AUTOREPEAT_EN enables auto-repeat of held
//   keys (rpt_delay / rpt_period); without it those parameters are unused.
// Ports:
//   clk       : clock, posedge
//   rst_n     : asynchronous active-low reset
//   key       : raw key levels, active-high
//   cmd_valid : command offered
//   cmd_ready : consumer accepts the command
//   cmd_sel   : target counter index (key index / 2)
//   cmd_inc   : 1 = increment, 0 = decrement (key index bit 0)
//   pending   : queued-press flag per key
//   overrun   : one-cycle pulse when a press event was dropped
module key_cmd_scheduler
  import key_cmd_scheduler_pkg::*;
#(
  parameter int clk_mhz    = 50,
  parameter int w_key      = 4,
  parameter int deb_cycles = clk_mhz * 1000 * 10,
  parameter int rpt_delay  = clk_mhz * 1000 * 500,
  parameter int rpt_period = clk_mhz * 1000 * 100,
  localparam int SEL_W     = (w_key / 2 > 1) ? $clog2(w_key / 2) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [w_key-1:0] key,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [SEL_W-1:0] cmd_sel,
  output logic             cmd_inc,
  output logic [w_key-1:0] pending,
  output logic             overrun
);

  localparam int IW = (w_key > 1) ? $clog2(w_key) : 1;

  if ((w_key < 2) || (w_key % 2 != 0) || (deb_cycles < 1) ||
      (rpt_delay < 1) || (rpt_period < 1)) begin : g_bad_params
    $error("key_cmd_scheduler: illegal parameter set");
  end

  logic [w_key-1:0] press;
  logic [w_key-1:0] clr;
  state_t           state;
  state_t           state_nxt;
  logic [IW-1:0]    last_grant;
  logic [IW-1:0]    grant;
  logic [IW-1:0]    grant_nxt;
  logic             grant_found;
  logic             load;
  logic             handshake;

  for (genvar k = 0; k < w_key; k++) begin : g_key
`ifdef KEY_CMD_SCHEDULER_AUTOREPEAT_EN
    key_debounce #(
      .deb_cycles (deb_cycles),
      .rpt_delay  (rpt_delay),
      .rpt_period (rpt_period)
    ) u_debounce (
`else
    key_debounce #(
      .deb_cycles (deb_cycles)
    ) u_debounce (
`endif
      .clk   (clk),
      .rst_n (rst_n),
      .key   (key[k]),
      .press (press[k])
    );
  end

  // cmd_valid comes straight from the state register, never from cmd_ready.
  assign cmd_valid = (state == OFFER);
  assign handshake = (state == OFFER) && cmd_ready;

  // Round-robin search starting one past the last granted key.
  always_comb begin
    logic [IW-1:0] idx;
    grant_found = 1'b0;
    grant_nxt   = last_grant;
    for (int i = 1; i <= w_key; i++) begin
      idx = IW'((int'(last_grant) + i) % w_key);
      if (!grant_found && pending[idx]) begin
        grant_found = 1'b1;
        grant_nxt   = idx;
      end
    end
  end

  always_comb begin
    clr = '0;
    if (handshake) clr[grant] = 1'b1;
  end

  // A press landing on the bit being cleared this cycle re-queues it instead
  // of counting as an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      overrun <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | press;
      overrun <= |(press & pending & ~clr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          state_nxt = OFFER;
          load      = 1'b1;
        end
      end
      OFFER: begin
        if (cmd_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant      <= '0;
      last_grant <= IW'(w_key - 1);
      cmd_sel    <= '0;
      cmd_inc    <= 1'b0;
    end else begin
      if (load) begin
        grant   <= grant_nxt;
        cmd_sel <= SEL_W'(key_to_cmd(32'(grant_nxt)) >> 1);
        cmd_inc <= 1'(key_to_cmd(32'(grant_nxt)));
      end
      if (handshake) last_grant <= grant;
    end
  end

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// tb_key_cmd_scheduler
//   Directed bench for key_cmd_scheduler with deb_cycles=4, rpt_delay=20,
//   rpt_period=8. Handshakes and overrun pulses are logged on the falling
//   edge; inputs change 1 time unit after the rising edge.
module tb_key_cmd_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [0:0] cmd_sel;
  logic       cmd_inc;
  logic [3:0] pending;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  int hs_cyc[$];
  int hs_key[$];
  int ovr_cnt = 0;

  key_cmd_scheduler #(
    .clk_mhz    (50),
    .w_key      (4),
    .deb_cycles (4),
    .rpt_delay  (20),
    .rpt_period (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key       (key),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_sel   (cmd_sel),
    .cmd_inc   (cmd_inc),
    .pending   (pending),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      cyc = cyc + 1;
      if (cmd_valid && cmd_ready) begin
        hs_cyc.push_back(cyc);
        hs_key.push_back(int'(cmd_sel) * 2 + int'(cmd_inc));
      end
      if (overrun) ovr_cnt = ovr_cnt + 1;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    key       = '0;
    cmd_ready = 1'b0;
    rst_n     = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int o;
    int n;

    // Reset values
    rst_n     = 1'b0;
    key       = '0;
    cmd_ready = 1'b0;
    tick(3);
    check("rst_valid",   cmd_valid, 0);
    check("rst_pending", pending,   0);
    check("rst_overrun", overrun,   0);
    check("rst_sel",     cmd_sel,   0);
    check("rst_inc",     cmd_inc,   0);
    rst_n = 1'b1;
    tick(1);

    // Single press of key1 -> counter 0 increment
    cmd_ready = 1'b1;
    b = hs_key.size();
    o = ovr_cnt;
    key[1] = 1'b1;
    tick(10);
    key = '0;
    tick(20);
    check("k1_count", hs_key.size() - b, 1);
    if (hs_key.size() > b) check("k1_key", hs_key[b], 1);
    check("k1_overrun", ovr_cnt - o, 0);

    // Bouncing key0 (pattern 1,1,0), then steady high
    do_reset();
    cmd_ready = 1'b1;
    b = hs_key.size();
    for (int i = 0; i < 30; i++) begin
      key[0] = (i % 3 != 2);
      tick(1);
    end
    key[0] = 1'b1;
    tick(12);
    key = '0;
    tick(20);
    check("bounce_count", hs_key.size() - b, 1);
    if (hs_key.size() > b) check("bounce_key", hs_key[b], 0);

    // Simultaneous key0/key3, twice; round-robin from last_grant
    do_reset();
    cmd_ready = 1'b1;
    b = hs_key.size();
    key = 4'b1001;
    tick(12);
    key = '0;
    tick(15);
    key = 4'b1001;
    tick(12);
    key = '0;
    tick(15);
    check("rr_count", hs_key.size() - b, 4);
    if (hs_key.size() >= b + 4) begin
      check("rr_first",  hs_key[b],     0);
      check("rr_second", hs_key[b + 1], 3);
      check("rr_third",  hs_key[b + 2], 0);
      check("rr_fourth", hs_key[b + 3], 3);
    end

    // Back-pressure: key2 pressed twice while ready is low
    do_reset();
    b = hs_key.size();
    o = ovr_cnt;
    key[2] = 1'b1;
    tick(10);
    key = '0;
    tick(10);
    key[2] = 1'b1;
    tick(10);
    key = '0;
    tick(10);
    check("bp_pending", pending, 4);
    check("bp_overrun", ovr_cnt - o, 1);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", cmd_valid, 1);
      check("bp_sel",   cmd_sel,   1);
      check("bp_inc",   cmd_inc,   0);
      tick(1);
    end
    check("bp_no_hs", hs_key.size() - b, 0);
    cmd_ready = 1'b1;
    tick(3);
    cmd_ready = 1'b0;
    tick(2);
    check("bp_count", hs_key.size() - b, 1);
    if (hs_key.size() > b) check("bp_key", hs_key[b], 2);
    check("bp_pending_clr", pending, 0);

    // Reset asserted while a command is offered
    do_reset();
    key[1] = 1'b1;
    n = 0;
    while (!cmd_valid && n < 30) begin
      tick(1);
      n++;
    end
    check("rst_offer_valid", cmd_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid",   cmd_valid, 0);
    check("rst_async_pending", pending,   0);
    key = '0;
    tick(3);
    rst_n = 1'b1;
    b = hs_key.size();
    cmd_ready = 1'b1;
    tick(40);
    check("rst_after_count", hs_key.size() - b, 0);
    check("rst_after_valid", cmd_valid, 0);

    // key3 held 60 cycles
    do_reset();
    cmd_ready = 1'b1;
    b = hs_key.size();
    key[3] = 1'b1;
    tick(60);
    key = '0;
    tick(30);
`ifdef KEY_CMD_SCHEDULER_AUTOREPEAT_EN
    check("hold_count", hs_key.size() - b, 6);
    if (hs_key.size() >= b + 6) begin
      check("hold_gap1", hs_cyc[b + 1] - hs_cyc[b],     20);
      check("hold_gap2", hs_cyc[b + 2] - hs_cyc[b + 1], 8);
      check("hold_gap3", hs_cyc[b + 3] - hs_cyc[b + 2], 8);
      check("hold_gap4", hs_cyc[b + 4] - hs_cyc[b + 3], 8);
      check("hold_gap5", hs_cyc[b + 5] - hs_cyc[b + 4], 8);
      for (int i = 0; i < 6; i++) check("hold_key", hs_key[b + i], 3);
    end
`else
    check("hold_count", hs_key.size() - b, 1);
    if (hs_key.size() > b) check("hold_key", hs_key[b], 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_cmd_scheduler.md
KEY_CMD_SCHEDULER -- requirements
Module: key_cmd_scheduler

Interface
REQ-001 Parameter clk_mhz, default 50, board clock in MHz.
REQ-002 Parameter w_key, default 4, number of keys; even, at least 2.
REQ-003 Parameter deb_cycles, default clk_mhz*1000*10, cycles a key must be stable before it is accepted (10 ms).
REQ-004 Parameter rpt_delay, default clk_mhz*1000*500, cycles a key is held before the first auto-repeat.
REQ-005 Parameter rpt_period, default clk_mhz*1000*100, cycles between subsequent auto-repeats.
REQ-006 Port clk, input, 1, the single clock; all logic is on posedge.
REQ-007 Port rst_n, input, 1, asynchronous active-low reset.
REQ-008 Port key, input, w_key, raw asynchronous key levels, active-high.
REQ-009 Port cmd_valid, output, 1, a command is offered.
REQ-010 Port cmd_ready, input, 1, the consumer accepts the command.
REQ-011 Port cmd_sel, output, max(1,$clog2(w_key/2)), target counter index, equal to key index / 2.
REQ-012 Port cmd_inc, output, 1, 1 = increment, 0 = decrement; equals key index bit 0.
REQ-013 Port pending, output, w_key, one queued-press flag per key.
REQ-014 Port overrun, output, 1, one-cycle pulse when a press event is dropped.

Function
REQ-015 Each key SHALL pass through a 2-flop synchronizer before any other logic.
REQ-016 The debounced level SHALL take the synchronized value only after that value has been stable for deb_cycles consecutive cycles; any change restarts the count.
REQ-017 A 0->1 transition of the debounced level SHALL produce a one-cycle press event for that key.
REQ-018 A press event SHALL set pending[k]; if pending[k] is already set and is not being cleared in that cycle, the event SHALL be dropped and overrun SHALL pulse.
REQ-019 The arbiter FSM SHALL have two states: IDLE and OFFER.
REQ-020 In IDLE with pending != 0, the FSM SHALL grant the first set bit searching round-robin from last_grant+1 (mod w_key), register cmd_sel and cmd_inc, and enter OFFER.
REQ-021 In OFFER, cmd_valid SHALL be 1, and cmd_sel and cmd_inc SHALL hold stable until cmd_valid & cmd_ready.
REQ-022 On the handshake, the FSM SHALL clear the granted pending bit, set last_grant to the granted index, and return to IDLE; the peak rate is one command per 2 cycles.
REQ-023 A press event on the granted key in the handshake cycle SHALL leave its pending bit set, with no overrun.
REQ-024 cmd_valid SHALL never depend combinationally on cmd_ready.

Reset
REQ-025 On rst_n = 0, asynchronously: synchronizers, debounced levels and timers SHALL go to 0, pending = 0, FSM = IDLE, last_grant = w_key-1, cmd_valid = 0, cmd_sel = 0, cmd_inc = 0, overrun = 0.
REQ-026 A key already held at reset release SHALL produce one press event after deb_cycles plus synchronizer latency.
REQ-027 Reset asserted during OFFER SHALL discard the offered command without a handshake.

Configuration
REQ-028 With KEY_CMD_SCHEDULER_AUTOREPEAT_EN defined, a key held debounced-high SHALL generate extra press events: the first rpt_delay cycles after its press event, then one every rpt_period cycles until release.
REQ-029 Repeat events SHALL follow REQ-018 (set pending or overrun).
REQ-030 Without KEY_CMD_SCHEDULER_AUTOREPEAT_EN, no repeat timers SHALL be built, rpt_delay and rpt_period SHALL be ignored, and one press yields exactly one event.

Structure
REQ-031 Package key_cmd_scheduler_pkg SHALL hold the FSM state enum (IDLE, OFFER) and the function mapping a key index to {sel, inc}.
REQ-032 Sub-module key_debounce (synchronizer, stability counter, press/repeat event generation) SHALL be instantiated w_key times.

Verification
Bench parameters: deb_cycles=4, rpt_delay=20, rpt_period=8.
REQ-033 key[1] held 10 cycles with cmd_ready=1 -> exactly one command, cmd_sel=0, cmd_inc=1; no overrun.
REQ-034 key[0] bouncing with a period of 3 cycles for 30 cycles, then held high -> exactly one command, cmd_sel=0, cmd_inc=0.
REQ-035 key[0] and key[3] pressed in the same cycle, cmd_ready=1 -> two commands in order key0, key3; a repeat with both pressed again -> order key3, key0 is NOT produced, order follows last_grant=3 giving key0, then key3.
REQ-036 cmd_ready=0, key[2] pressed twice -> pending=4'b0100, overrun pulses once; cmd_sel=1, cmd_inc=0 stable until ready rises; one handshake, then pending=0.
REQ-037 rst_n pulled low during OFFER -> cmd_valid=0 and pending=0 immediately; no command after release while keys are low.
REQ-038 Macro defined, key[3] held 60 cycles, cmd_ready=1 -> commands at press, +20, +28, +36, +44, +52 cycles (6 total), all cmd_sel=1, cmd_inc=1; macro undefined -> 1 command.
